uart_tx_arbiter: RTL and testbench

// - Shares one uart_tx byte transmitter among N_REQ byte sources (e.g. TL-UL UART CSR path, debug/boot log).
// - Round-robin grant per byte, one-cycle tx_en launch, tracks tx done, enforces inter-byte gap, done-watchdog.
// - Sits between requester valid/ready byte ports and the uart_tx tx_en/i_TX_Byte/o_TX_Done pins.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter_rr_arb.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the uart_tx byte arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      BUSY,
      GAP
   } arb_state_e;

   localparam int unsigned UART_BYTE_W = 8;
   localparam int unsigned DEF_N_REQ   = 4;
   localparam int unsigned DEF_GAP_W   = 8;
   localparam int unsigned DEF_TO_W    = 20;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte handshake bundle: per-requester valid/data in,
// one-hot ready/done strobes back.
interface uart_tx_arbiter_if #(
   parameter int unsigned N_REQ = uart_pkg::DEF_N_REQ
);

   logic [N_REQ-1:0]                       req_valid_i;
   logic [N_REQ*uart_pkg::UART_BYTE_W-1:0] req_data_i;
   logic [N_REQ-1:0]                       req_ready_o;
   logic [N_REQ-1:0]                       req_done_o;

   modport master (
      output req_valid_i,
      output req_data_i,
      input  req_ready_o,
      input  req_done_o
   );

   modport slave (
      input  req_valid_i,
      input  req_data_i,
      output req_ready_o,
      output req_done_o
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after
// ptr_i (wrapping), returned as one-hot grant plus index.
module rr_arb #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   logic [IDX_W-1:0] cand;

   // Scan requests starting at the pointer; the first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((32'(ptr_i) + k) % N_REQ);
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
      if (any_o) begin
         gnt_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte transmitter among N_REQ byte sources: round-robin
// accept, one-cycle tx_en launch, done edge tracking, post-byte idle gap and
// a done watchdog.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int unsigned N_REQ = DEF_N_REQ,
   parameter  int unsigned GAP_W = DEF_GAP_W,
   parameter  int unsigned TO_W  = DEF_TO_W,
   localparam int unsigned IDX_W = $clog2(N_REQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic [GAP_W-1:0]       gap_cycles_i,
   input  logic [TO_W-1:0]        timeout_i,
   uart_tx_arbiter_if.slave       req_if,
   output logic                   tx_en_o,
   output logic [UART_BYTE_W-1:0] tx_byte_o,
   input  logic                   tx_done_i,
   output logic                   busy_o,
   output logic [IDX_W-1:0]       owner_o,
   output logic                   err_o
);

   arb_state_e             state_q, state_d;
   logic [IDX_W-1:0]       rr_q, rr_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
   logic                   tx_en_q, tx_en_d;
   logic                   done_q, done_d;
   logic [GAP_W-1:0]       gap_q, gap_d;
   logic [TO_W-1:0]        wd_q, wd_d;

   logic [N_REQ-1:0]       arb_gnt;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_any;
   logic                   accept;
   logic                   done_rise;
   logic                   wd_hit;
   logic [N_REQ-1:0]       ready;
   logic [N_REQ-1:0]       done_pulse;
   logic                   err;

   rr_arb #(
      .N_REQ (N_REQ)
   ) u_rr_arb (
      .req_i (req_if.req_valid_i),
      .ptr_i (rr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   // State and datapath registers; reset returns everything to idle zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         owner_q   <= '0;
         tx_byte_q <= '0;
         tx_en_q   <= 1'b0;
         done_q    <= 1'b0;
         gap_q     <= '0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         owner_q   <= owner_d;
         tx_byte_q <= tx_byte_d;
         tx_en_q   <= tx_en_d;
         done_q    <= done_d;
         gap_q     <= gap_d;
         wd_q      <= wd_d;
      end
   end

   // Next-state, counters and strobes for the IDLE->LAUNCH->BUSY->GAP cycle.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      owner_d    = owner_q;
      tx_byte_d  = tx_byte_q;
      tx_en_d    = 1'b0;
      done_d     = tx_done_i;
      gap_d      = gap_q;
      wd_d       = wd_q;
      ready      = '0;
      done_pulse = '0;
      err        = 1'b0;

      // Accept is also blocked while reset is held so ready reads zero then.
      accept    = (state_q == IDLE) && !rst_i && enable_i && arb_any;
      done_rise = tx_done_i && !done_q;
      wd_hit    = (timeout_i != '0) && (wd_q == timeout_i);

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               ready   = arb_gnt;
               owner_d = arb_idx;
               rr_d    = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
               for (int unsigned k = 0; k < N_REQ; k++) begin
                  if (IDX_W'(k) == arb_idx) begin
                     tx_byte_d = req_if.req_data_i[k*UART_BYTE_W +: UART_BYTE_W];
                  end
               end
               tx_en_d = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            // Watchdog holds the number of cycles elapsed since the launch.
            wd_d    = TO_W'(1);
            state_d = BUSY;
         end
         BUSY: begin
            if (done_rise) begin
               done_pulse[owner_q] = 1'b1;
               gap_d               = gap_cycles_i;
               state_d             = GAP;
            end else if (wd_hit) begin
               err     = 1'b1;
               gap_d   = gap_cycles_i;
               state_d = GAP;
            end else if (wd_q != '1) begin
               wd_d = wd_q + 1'b1;
            end
         end
         GAP: begin
            // Also wait out the transmitter's done window before re-arming.
            if ((gap_q == '0) && !tx_done_i) begin
               state_d = IDLE;
            end else if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_if.req_ready_o = ready;
   assign req_if.req_done_o  = done_pulse;
   assign tx_en_o            = tx_en_q;
   assign tx_byte_o          = tx_byte_q;
   assign busy_o             = (state_q != IDLE);
   assign owner_o            = owner_q;
   assign err_o              = err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: randomized requesters, a uart_tx model with
// CLKS_PER_BIT=4, a serial decoder and a queue-based reference model.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned GAP_W = 8;
   localparam int unsigned TO_W  = 20;
   localparam int          CPB   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b0;
   logic [GAP_W-1:0] gap_cycles = '0;
   logic [TO_W-1:0]  timeout = '0;
   logic             tx_en;
   logic [7:0]       tx_byte;
   logic             tx_done;
   logic             busy;
   logic [1:0]       owner;
   logic             err;

   uart_tx_arbiter_if #(.N_REQ(N_REQ)) req_if ();

   uart_tx_arbiter #(
      .N_REQ (N_REQ),
      .GAP_W (GAP_W),
      .TO_W  (TO_W)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (enable),
      .gap_cycles_i (gap_cycles),
      .timeout_i    (timeout),
      .req_if       (req_if),
      .tx_en_o      (tx_en),
      .tx_byte_o    (tx_byte),
      .tx_done_i    (tx_done),
      .busy_o       (busy),
      .owner_o      (owner),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- uart_tx model ----------------
   logic       m_busy;
   logic [3:0] m_bit;
   logic [1:0] m_ck;
   logic [9:0] m_sh;
   logic [1:0] m_dcnt;
   logic       done_tie0 = 1'b0;
   logic       line;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_bit <= '0; m_ck <= '0; m_sh <= '1; m_dcnt <= '0;
      end else if (m_busy) begin
         if (m_ck == 2'(CPB - 1)) begin
            m_ck <= '0;
            if (m_bit == 4'd9) begin
               m_busy <= 1'b0;
               m_dcnt <= 2'd2;
            end else begin
               m_bit <= m_bit + 4'd1;
            end
         end else begin
            m_ck <= m_ck + 2'd1;
         end
      end else if (m_dcnt != 0) begin
         m_dcnt <= m_dcnt - 2'd1;
      end else if (tx_en) begin
         m_busy <= 1'b1;
         m_sh   <= {1'b1, tx_byte, 1'b0};
         m_bit  <= '0;
         m_ck   <= '0;
      end
   end

   assign line    = m_busy ? m_sh[m_bit] : 1'b1;
   assign tx_done = (m_dcnt != 0) && !done_tie0;

   // ---------------- reference model state ----------------
   logic [7:0]       src_q [N_REQ][$];
   logic [7:0]       ser_q [$];
   int               own_q [$];
   logic [7:0]       acc_log [$];
   int               acc_own [$];
   logic [N_REQ-1:0] taken = '0;
   int               drop_pct = 0;
   int               cyc = 0;
   int               rr_m = 0;
   bit               exp_tx_en = 0;
   logic [7:0]       exp_byte = '0;
   int               exp_owner = 0;
   int               last_en_cyc = 0;
   int               done_cyc = 0;
   int               ref_cyc = 0;
   int               ref_gap = 0;
   bit               have_ref = 0;
   bit               prev_done = 0;
   int               n_acc = 0;
   int               n_done = 0;
   int               n_errp = 0;
   bit               dec_active = 0;
   bit               dec_abort = 0;

   // Per-cycle monitor, sampled on the falling edge.
   int               w;
   int               c;
   logic [N_REQ-1:0] exp_rdy;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         rr_m = 0; exp_tx_en = 0; have_ref = 0; taken = '0;
         own_q.delete();
      end else begin
         exp_rdy = '0;
         w = -1;
         if (!busy && enable && (req_if.req_valid_i != '0)) begin
            for (int k = 0; k < N_REQ; k++) begin
               c = (rr_m + k) % N_REQ;
               if (w < 0 && req_if.req_valid_i[c]) w = c;
            end
            exp_rdy[w] = 1'b1;
         end
         check("ready", 32'(req_if.req_ready_o), 32'(exp_rdy));
         taken = req_if.req_ready_o & req_if.req_valid_i;

         check("tx_en", 32'(tx_en), 32'(exp_tx_en));
         if (tx_en) begin
            check("tx_byte", 32'(tx_byte), 32'(exp_byte));
            check("owner", 32'(owner), 32'(exp_owner));
            check("tx_en_during_done", 32'(tx_done), 0);
            check("uart_idle_at_tx_en", 32'(m_busy || (m_dcnt != 0)), 0);
            if (have_ref) check("gap_min", 32'((cyc - ref_cyc - 1) >= ref_gap), 1);
            last_en_cyc = cyc;
         end

         exp_tx_en = 0;
         if (w >= 0) begin
            exp_tx_en = 1;
            exp_byte  = req_if.req_data_i[w*8 +: 8];
            exp_owner = w;
            rr_m      = (w + 1) % N_REQ;
            own_q.push_back(w);
            ser_q.push_back(exp_byte);
            acc_log.push_back(exp_byte);
            acc_own.push_back(w);
            n_acc++;
         end

         if (req_if.req_done_o != '0) begin
            check("done_on_rise", 32'(tx_done && !prev_done), 1);
            if (own_q.size() == 0) check("done_extra", 1, 0);
            else check("done_owner", 32'(req_if.req_done_o), 32'(1) << own_q.pop_front());
            n_done++;
            done_cyc = cyc; ref_cyc = cyc; ref_gap = int'(gap_cycles); have_ref = 1;
         end

         if (err) begin
            check("err_time", 32'(cyc - last_en_cyc), 32'(timeout));
            if (own_q.size() != 0) void'(own_q.pop_front());
            n_errp++;
            ref_cyc = cyc; ref_gap = int'(gap_cycles); have_ref = 1;
         end
      end
      prev_done = tx_done;
   end

   // Serial decoder: mid-bit sampling of the model's line.
   logic [7:0] dec_b;
   logic       dec_stop;
   initial begin
      forever begin
         @(negedge clk);
         if (line === 1'b0) begin
            dec_active = 1;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               dec_b[i] = line;
            end
            repeat (CPB) @(negedge clk);
            dec_stop = line;
            if (!dec_abort) begin
               if (ser_q.size() == 0) begin
                  check("ser_extra", 1, 0);
               end else begin
                  check("ser_byte", 32'(dec_b), 32'(ser_q.pop_front()));
                  check("ser_stop", 32'(dec_stop), 1);
               end
            end
            dec_abort  = 0;
            dec_active = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [N_REQ-1:0]   vld;
   logic [N_REQ*8-1:0] dat;

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < N_REQ; k++) begin
         if (taken[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
      end
      vld = '0;
      dat = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (src_q[k].size() != 0) begin
            dat[k*8 +: 8] = src_q[k][0];
            vld[k] = ($urandom_range(99) >= drop_pct);
         end else begin
            dat[k*8 +: 8] = 8'($urandom);
         end
      end
      req_if.req_valid_i = vld;
      req_if.req_data_i  = dat;
   endtask

   function automatic bit pending();
      bit p = 0;
      for (int k = 0; k < N_REQ; k++) if (src_q[k].size() != 0) p = 1;
      return p || busy || m_busy || (m_dcnt != 0) || (own_q.size() != 0);
   endfunction

   task automatic drain(input int maxc, input string tag);
      int n = 0;
      while (pending() && n < maxc) begin
         step();
         n++;
      end
      check({tag, "_drain_bound"}, 32'(n < maxc), 1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      if (dec_active) dec_abort = 1;
      #1;
      check("rst_tx_en", 32'(tx_en), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_owner", 32'(owner), 0);
      check("rst_err", 32'(err), 0);
      check("rst_tx_byte", 32'(tx_byte), 0);
      check("rst_ready", 32'(req_if.req_ready_o), 0);
      check("rst_done", 32'(req_if.req_done_o), 0);
      ser_q.delete();
      for (int k = 0; k < N_REQ; k++) src_q[k].delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   int a0, d0, e0, base, wn;

   initial begin
      req_if.req_valid_i = '0;
      req_if.req_data_i  = '0;
      do_reset();

      // Single byte from requester 0, no gap.
      enable = 1'b1; gap_cycles = 8'd0; drop_pct = 0;
      a0 = n_acc; d0 = n_done;
      src_q[0].push_back(8'hA5);
      drain(300, "single");
      check("single_acc", 32'(n_acc - a0), 1);
      check("single_done", 32'(n_done - d0), 1);
      check("single_done_lat", 32'(done_cyc - last_en_cyc), 41);

      // All four requesters continuously valid, round-robin order.
      do_reset();
      enable = 1'b1; gap_cycles = 8'd1; drop_pct = 0;
      base = acc_log.size(); d0 = n_done;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < N_REQ; k++) src_q[k].push_back(8'(8'h10 * (r + 1) + k));
      drain(1500, "rr");
      check("rr_count", 32'(acc_log.size() - base), 12);
      check("rr_done", 32'(n_done - d0), 12);
      for (int i = 0; i < 12 && base + i < acc_log.size(); i++) begin
         check("rr_byte", 32'(acc_log[base + i]), 32'(8'h10 * (i / 4 + 1) + i % 4));
         check("rr_owner", 32'(acc_own[base + i]), 32'(i % 4));
      end

      // Random requesters with gap 5 and requesters dropping valid.
      gap_cycles = 8'd5; drop_pct = 30;
      a0 = n_acc; d0 = n_done;
      for (int i = 0; i < 8; i++) src_q[$urandom_range(N_REQ - 1)].push_back(8'($urandom));
      drain(3000, "gap");
      check("gap_acc", 32'(n_acc - a0), 8);
      check("gap_done", 32'(n_done - d0), 8);

      // Watchdog: done never returned.
      timeout = 20'd8; done_tie0 = 1'b1; gap_cycles = 8'd3; drop_pct = 0;
      a0 = n_acc; d0 = n_done; e0 = n_errp;
      src_q[2].push_back(8'h5A);
      drain(300, "wdog");
      check("wdog_err", 32'(n_errp - e0), 1);
      check("wdog_no_done", 32'(n_done - d0), 0);
      check("wdog_idle", 32'(busy), 0);
      done_tie0 = 1'b0;
      timeout = 20'd100;

      // enable dropped right after an accept.
      gap_cycles = 8'd2;
      a0 = n_acc; d0 = n_done;
      src_q[3].push_back(8'h77);
      wn = 0;
      while (n_acc == a0 && wn < 50) begin step(); wn++; end
      check("en_accept_bound", 32'(wn < 50), 1);
      enable = 1'b0;
      src_q[1].push_back(8'h81);
      src_q[1].push_back(8'h82);
      wn = 0;
      while (n_done == d0 && wn < 120) begin step(); wn++; end
      check("en_done_bound", 32'(wn < 120), 1);
      repeat (30) step();
      check("en_hold_acc", 32'(n_acc - a0), 1);
      check("en_hold_done", 32'(n_done - d0), 1);
      enable = 1'b1;
      drain(500, "en");
      check("en_resume_acc", 32'(n_acc - a0), 3);
      check("en_resume_last", 32'(acc_log[acc_log.size() - 1]), 32'h82);

      // Reset while a byte is in flight, then a clean byte from requester 1.
      timeout = '0; gap_cycles = 8'd0;
      e0 = last_en_cyc;
      src_q[0].push_back(8'hC3);
      wn = 0;
      while (last_en_cyc == e0 && wn < 50) begin step(); wn++; end
      check("mid_launch_bound", 32'(wn < 50), 1);
      repeat (10) step();
      d0 = n_done; e0 = n_errp;
      do_reset();
      repeat (50) step();
      check("mid_rst_no_done", 32'(n_done - d0), 0);
      check("mid_rst_no_err", 32'(n_errp - e0), 0);
      a0 = n_acc;
      src_q[1].push_back(8'h3C);
      drain(300, "post_rst");
      check("post_rst_acc", 32'(n_acc - a0), 1);
      check("post_rst_done", 32'(n_done - d0), 1);
      check("post_rst_byte", 32'(acc_log[acc_log.size() - 1]), 32'h3C);
      check("post_rst_owner", 32'(acc_own[acc_own.size() - 1]), 1);

      repeat (5) step();
      check("ser_left", 32'(ser_q.size()), 0);
      check("own_left", 32'(own_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
